ducq_nco: RTL
=============

Name: ducq_nco

Overview:
- Phase-generation stage directly upstream of the DUC complex rotator.
- Accepts interpolated baseband I/Q samples with a valid strobe and runs a phase accumulator at the carrier frequency control word.
- Emits each sample with its 12-bit rotation phase (4096 counts per 2π; bits [11:10] quadrant, bit [9] octant, [8:0] in-octant) and a start strobe, time-aligned for the rotator.
- No backpressure: the downstream rotator accepts one sample per cycle.

Parameters:
- ACC_W, 24, phase accumulator width in bits; legal range 16..27; o_z is taken from the top 12 bits.
- DW, 14, I/Q sample width (signed Q2.11).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- i_enable  in  1  block enable; when low, i_valid is ignored
- i_clear  in  1  synchronous phase clear
- i_valid  in  1  input sample strobe
- i_x  in  DW  input I sample
- i_y  in  DW  input Q sample
- i_fcw  in  ACC_W  frequency control word, unsigned, modulo 2^ACC_W
- i_fcw_load  in  1  capture i_fcw into the active FCW register
- i_phase_ofs  in  12  static phase offset added after truncation
- o_start  out  1  output sample strobe (drives rotator i_start)
- o_x  out  DW  delayed I sample
- o_y  out  DW  delayed Q sample
- o_z  out  12  rotation phase for this sample

Behaviour:
- Clock and reset: single clock clk. Reset reset_n is asynchronous and active-low.
- Reset values: o_start=0, o_x=0, o_y=0, o_z=0, accumulator=0, active FCW=0, all pipeline valids=0.
- Accept condition: acc_en = i_valid & i_enable.
- Accumulator:
  - On acc_en, the sample is tagged with the current accumulator value, then acc <= acc + fcw_active, modulo 2^ACC_W.
  - The wrap is silent.
  - The first sample after reset or clear is tagged with phase 0.
- FCW load:
  - i_fcw_load captures i_fcw into fcw_active at that clock edge.
  - The new value first affects the increment of the next cycle.
  - An accepted sample in the same cycle as the load uses the old FCW for its increment.
- Clear:
  - In a cycle where i_clear=1 the accumulator is forced.
  - If acc_en is also 1, the sample is accepted and tagged with phase 0, and acc <= fcw_active.
  - Otherwise acc <= 0.
  - Clear does not flush samples already in the pipeline, and does not alter fcw_active.
- Pipeline: two register stages, fixed latency of 2 cycles from accept to o_start.
  - Stage 1 registers: x, y, tagged acc, i_phase_ofs, valid.
  - Stage 2 computes o_z = (acc[ACC_W-1:ACC_W-12] + ofs) mod 4096 and registers o_x, o_y, o_z and o_start = stage-1 valid.
- Hold and throughput:
  - o_x, o_y and o_z hold their last values when o_start=0.
  - o_start is a one-cycle pulse per accepted sample.
  - Back-to-back accepts give back-to-back o_start pulses.
- i_enable low: new samples are dropped and the accumulator freezes. In-flight samples still drain within 2 cycles.
- Reset mid-stream: all in-flight samples are discarded, with no o_start pulse after reset deasserts until a new accept occurs.

Optional Feature:
- Macro: DUCQ_NCO_DITHER_EN.
- Defined:
  - A 15-bit Fibonacci LFSR (x^15+x^14+1) is seeded to 15'h0001 on reset and on i_clear.
  - The LFSR advances once per accepted sample.
  - In stage 2, dither = LFSR low min(ACC_W-12, 15) bits is added to the tagged acc's low bits, aligned at bit 0, before truncation. The carry propagates into the 12-bit phase, modulo 2^ACC_W.
  - Latency is unchanged.
- Undefined: plain truncation. No LFSR logic is present.

Test Plan:
- Step sequence: ACC_W=24, load fcw=24'h100000, ofs=0, 4 consecutive valids -> o_z = 0, 256, 512, 768 on 4 consecutive o_start pulses, first pulse 2 cycles after the first i_valid, o_x/o_y equal to the inputs.
- Wrap-around: fcw=24'hF00000, 3 valids -> o_z = 0, 3840, 3584. Then fcw=24'h800000 from accumulator 24'hE00000 -> accumulator wraps, next o_z = 3584 then 1536.
- Offset and modulo: ofs=12'hC00, fcw=24'h400000, 3 valids -> o_z = 3072, 0, 1024.
- Load/clear collision: fcw active = 24'h100000, same cycle i_fcw_load with 24'h200000 and i_valid -> the next sample's o_z steps by 256; the following sample steps by 512. i_clear with i_valid -> that sample's o_z = ofs, and the next = ofs + fcw>>12.
- Enable gating and reset: i_enable=0 with 5 valids -> no o_start, accumulator unchanged. Assert reset_n=0 one cycle after a valid -> no o_start after release, o_z=0, next accept gives o_z = ofs.
- Dither (macro defined): fcw=24'h000800 (half LSB of o_z), 1000 valids -> o_z mean slope 0.5 LSB/sample within ±2 LSB after 1000 samples. Macro undefined -> o_z advances exactly 1 every 2 samples.

Source files
------------

// File: rtl/ducq_nco.sv
// Phase generator in front of the DUC rotator: phase accumulator, two-stage sample/phase alignment.
// Optional accumulator dither is built when DUCQ_NCO_DITHER_EN is defined.
module ducq_nco #(
    parameter int ACC_W = 24,
    parameter int DW    = 14
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_enable,
    input  logic             i_clear,
    input  logic             i_valid,
    input  logic [DW-1:0]    i_x,
    input  logic [DW-1:0]    i_y,
    input  logic [ACC_W-1:0] i_fcw,
    input  logic             i_fcw_load,
    input  logic [11:0]      i_phase_ofs,
    output logic             o_start,
    output logic [DW-1:0]    o_x,
    output logic [DW-1:0]    o_y,
    output logic [11:0]      o_z
);

    logic             acc_en_s;
    logic [ACC_W-1:0] acc_r;
    logic [ACC_W-1:0] acc_nxt_s;
    logic [ACC_W-1:0] tag_s;
    logic [ACC_W-1:0] fcw_r;
    logic [DW-1:0]    s1_x_r;
    logic [DW-1:0]    s1_y_r;
    logic [ACC_W-1:0] s1_acc_r;
    logic [11:0]      s1_ofs_r;
    logic             s1_vld_r;
    logic [ACC_W-1:0] phase_acc_s;
    logic [11:0]      z_s;

    assign acc_en_s = i_valid & i_enable;

    // Accumulator next value and sample tag; clear restarts the sequence at phase 0
    always_comb begin
        acc_nxt_s = acc_r;
        tag_s     = acc_r;
        if (i_clear) begin
            tag_s = {ACC_W{1'b0}};
            if (acc_en_s) begin
                acc_nxt_s = fcw_r;
            end else begin
                acc_nxt_s = {ACC_W{1'b0}};
            end
        end else if (acc_en_s) begin
            acc_nxt_s = acc_r + fcw_r;
        end else begin
            acc_nxt_s = acc_r;
        end
    end

    // Accumulator and active frequency word; a load only affects later increments
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_r <= {ACC_W{1'b0}};
            fcw_r <= {ACC_W{1'b0}};
        end else begin
            acc_r <= acc_nxt_s;
            if (i_fcw_load) begin
                fcw_r <= i_fcw;
            end
        end
    end

    // Stage 1: capture the accepted sample with its phase tag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_x_r   <= {DW{1'b0}};
            s1_y_r   <= {DW{1'b0}};
            s1_acc_r <= {ACC_W{1'b0}};
            s1_ofs_r <= 12'd0;
            s1_vld_r <= 1'b0;
        end else begin
            s1_vld_r <= acc_en_s;
            if (acc_en_s) begin
                s1_x_r   <= i_x;
                s1_y_r   <= i_y;
                s1_acc_r <= tag_s;
                s1_ofs_r <= i_phase_ofs;
            end
        end
    end

`ifdef DUCQ_NCO_DITHER_EN
    localparam int DITH_W = ((ACC_W - 12) < 15) ? (ACC_W - 12) : 15;

    logic [14:0]       lfsr_r;
    logic [14:0]       lfsr_nxt_s;
    logic [DITH_W-1:0] dith_tag_s;
    logic [DITH_W-1:0] s1_dith_r;

    // x^15 + x^14 + 1 Fibonacci step
    function automatic logic [14:0] lfsr_step(input logic [14:0] s);
        return {s[13:0], s[14] ^ s[13]};
    endfunction

    // LFSR reseeds on clear so a cleared stream repeats its dither pattern
    always_comb begin
        lfsr_nxt_s = lfsr_r;
        dith_tag_s = lfsr_r[DITH_W-1:0];
        if (i_clear) begin
            dith_tag_s = {{(DITH_W-1){1'b0}}, 1'b1};
            if (acc_en_s) begin
                lfsr_nxt_s = lfsr_step(15'h0001);
            end else begin
                lfsr_nxt_s = 15'h0001;
            end
        end else if (acc_en_s) begin
            lfsr_nxt_s = lfsr_step(lfsr_r);
        end else begin
            lfsr_nxt_s = lfsr_r;
        end
    end

    // LFSR state and per-sample dither tag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lfsr_r    <= 15'h0001;
            s1_dith_r <= {{(DITH_W-1){1'b0}}, 1'b1};
        end else begin
            lfsr_r <= lfsr_nxt_s;
            if (acc_en_s) begin
                s1_dith_r <= dith_tag_s;
            end
        end
    end

    assign phase_acc_s = s1_acc_r + {{(ACC_W-DITH_W){1'b0}}, s1_dith_r};
`else
    assign phase_acc_s = s1_acc_r;
`endif

    assign z_s = phase_acc_s[ACC_W-1 -: 12] + s1_ofs_r;

    // Stage 2: registered outputs, data held between strobes
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            o_start <= 1'b0;
            o_x     <= {DW{1'b0}};
            o_y     <= {DW{1'b0}};
            o_z     <= 12'd0;
        end else begin
            o_start <= s1_vld_r;
            if (s1_vld_r) begin
                o_x <= s1_x_r;
                o_y <= s1_y_r;
                o_z <= z_s;
            end
        end
    end

endmodule
